// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared state type, product width and sign-extension helper for prod_accum
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int PROD_W = 20;

  // Widest accumulator the helper can serve; callers narrow the result to their ACC_W.
  localparam int EXT_W = 128;

  // Sign-extends a multiplier product so later negation is exact, including -2^(PROD_W-1).
  function automatic logic signed [EXT_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return EXT_W'(p);
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// rtl/prod_accum_if.sv - product stream, run control and result handshake bundle for prod_accum
interface prod_accum_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  import prod_accum_pkg::*;

  logic                     start;
  logic [CNT_W-1:0]         len;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_sub;
  logic                     prod_valid;
  logic                     prod_ready;
  logic                     busy;
  logic signed [ACC_W-1:0]  res;
  logic                     res_valid;
  logic                     res_ready;
  logic                     ovf;

  modport master (
    output start, len, prod, prod_sub, prod_valid, res_ready,
    input  prod_ready, busy, res, res_valid, ovf
  );

  modport slave (
    input  start, len, prod, prod_sub, prod_valid, res_ready,
    output prod_ready, busy, res, res_valid, ovf
  );

endinterface

// File: rtl/prod_accum_add.sv
// rtl/prod_accum_add.sv - combinational add/sub of one term with overflow detect; clamps when PROD_ACCUM_SAT_EN is defined
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  input  logic                     sub,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  logic signed [ACC_W-1:0] term_ext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] raw;

  // Extend before negating so the most negative product negates without loss.
  assign term_ext = ACC_W'(sext_prod(prod));
  assign term     = sub ? -term_ext : term_ext;
  assign raw      = acc + term;

  // Like-signed operands producing an opposite-signed result is the only overflow case.
  assign ovf = (acc[ACC_W-1] == term[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef PROD_ACCUM_SAT_EN
  // Clamp toward the rail the operands were heading for instead of wrapping.
  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - run-length product accumulator with result handshake (saturation via PROD_ACCUM_SAT_EN)
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic          sys_clk,
  input logic          reset,
  prod_accum_if.slave  bus
);

  state_t                  state, state_next;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [ACC_W-1:0] res_q, res_next;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    ovf_q, ovf_next;
  logic                    add_ovf;
  logic                    launch;

  prod_accum_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .prod (bus.prod),
    .sub  (bus.prod_sub),
    .sum  (sum),
    .ovf  (add_ovf)
  );

  assign bus.prod_ready = (state == ACCUM);
  assign bus.busy       = (state != IDLE);
  assign bus.res_valid  = (state == HOLD);
  assign bus.res        = res_q;
  assign bus.ovf        = ovf_q;

  // Next-state and datapath updates; a start taken in HOLD alongside res_ready launches with no idle cycle.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    res_next   = res_q;
    ovf_next   = ovf_q;
    launch     = 1'b0;
    case (state)
      IDLE: launch = bus.start;
      ACCUM: begin
        if (bus.prod_valid) begin
          acc_next = sum;
          cnt_next = cnt - CNT_W'(1);
          if (add_ovf) ovf_next = 1'b1;
          if (cnt == CNT_W'(1)) begin
            res_next   = sum;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_next = IDLE;
          launch     = bus.start;
        end
      end
      default: state_next = IDLE;
    endcase
    if (launch) begin
      acc_next = '0;
      ovf_next = 1'b0;
      if (bus.len != '0) begin
        cnt_next   = bus.len;
        state_next = ACCUM;
      end else begin
        cnt_next   = '0;
        res_next   = '0;
        state_next = HOLD;
      end
    end
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      res_q <= res_next;
      ovf_q <= ovf_next;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - randomized and directed checks of prod_accum against an exact-arithmetic model
module tb_prod_accum;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));
  localparam longint MODV = longint'(1) << ACC_W;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  prod_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  prod_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  int     tp[$];
  bit     ts[$];
  int     tg[$];
  longint exp_acc;
  bit     exp_ovf;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Exact integer sum, then range check; out of range is overflow, resolved by wrap or clamp.
  function automatic longint model_step(input longint a, input int p, input bit s, output bit o);
    longint exact;
    longint m;
    exact = a + (s ? -longint'(p) : longint'(p));
    o = (exact > MAXV) || (exact < MINV);
`ifdef PROD_ACCUM_SAT_EN
    if (exact > MAXV) return MAXV;
    if (exact < MINV) return MINV;
    return exact;
`else
    m = exact % MODV;
    if (m < 0) m += MODV;
    if (m > MAXV) m -= MODV;
    return m;
`endif
  endfunction

  task automatic begin_run(input int n);
    bus.start = 1'b1;
    bus.len   = CNT_W'(n);
    exp_acc   = 0;
    exp_ovf   = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic feed();
    bit o;
    for (int i = 0; i < tp.size(); i++) begin
      for (int k = 0; k < tg[i]; k++) begin
        bus.prod_valid = 1'b0;
        bus.prod       = 20'($urandom);
        chk("stall_ready", bus.prod_ready, 1);
        @(negedge sys_clk);
      end
      bus.prod       = 20'(tp[i]);
      bus.prod_sub   = ts[i];
      bus.prod_valid = 1'b1;
      chk("term_ready", bus.prod_ready, 1);
      chk("early_valid", bus.res_valid, 0);
      exp_acc = model_step(exp_acc, tp[i], ts[i], o);
      if (o) exp_ovf = 1'b1;
      @(negedge sys_clk);
    end
    bus.prod_valid = 1'b0;
    chk("res_valid", bus.res_valid, 1);
    chk("res", bus.res, exp_acc);
    chk("ovf", bus.ovf, exp_ovf);
    chk("ready_in_hold", bus.prod_ready, 0);
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.res_ready = 1'b0;
    chk("released_valid", bus.res_valid, 0);
    chk("released_busy", bus.busy, 0);
    chk("released_ovf", bus.ovf, exp_ovf);
  endtask

  task automatic clear_terms();
    tp.delete();
    ts.delete();
    tg.delete();
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.prod = '0; bus.prod_sub = 1'b0;
    bus.prod_valid = 1'b0; bus.res_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    chk("rst_res", bus.res, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_ready", bus.prod_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);

    // Basic run.
    clear_terms();
    tp = '{100, -50, 7}; ts = '{0, 0, 0}; tg = '{0, 0, 0};
    begin_run(3);
    chk("basic_busy", bus.busy, 1);
    feed();
    chk("basic_res57", bus.res, 57);
    release_res();
    chk("basic_res_hold", bus.res, 57);

    // Subtraction with a four-cycle stall.
    clear_terms();
    tp = '{1000, -262144}; ts = '{1, 1}; tg = '{0, 4};
    begin_run(2);
    feed();
    chk("sub_res", bus.res, 261144);
    release_res();

    // Zero-length run.
    begin_run(0);
    chk("len0_valid", bus.res_valid, 1);
    chk("len0_res", bus.res, 0);
    chk("len0_ready", bus.prod_ready, 0);
    release_res();

    // Overflow run.
    clear_terms();
    for (int i = 0; i < 32; i++) begin tp.push_back(262144); ts.push_back(1'b0); tg.push_back(0); end
    begin_run(32);
    feed();
    chk("ovf_flag", bus.ovf, 1);

    // Held result ignores start until res_ready.
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.len = CNT_W'(4); bus.res_ready = 1'b0;
      @(negedge sys_clk);
      chk("hold_res", bus.res, exp_acc);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_ready", bus.prod_ready, 0);
    end
    bus.start = 1'b1; bus.len = CNT_W'(1); bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0; bus.res_ready = 1'b0;
    chk("b2b_accum", bus.prod_ready, 1);
    chk("b2b_ovf_clr", bus.ovf, 0);
    chk("b2b_valid", bus.res_valid, 0);
    exp_acc = 0; exp_ovf = 1'b0;
    clear_terms();
    tp = '{-7}; ts = '{1}; tg = '{0};
    feed();
    chk("b2b_res", bus.res, 7);
    release_res();

    // Reset in the middle of a run.
    begin_run(5);
    bus.prod = 20'(11); bus.prod_sub = 1'b0; bus.prod_valid = 1'b1;
    repeat (2) @(negedge sys_clk);
    bus.prod_valid = 1'b0;
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    chk("mid_rst_res", bus.res, 0);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_ready", bus.prod_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    clear_terms();
    tp = '{9}; ts = '{0}; tg = '{0};
    begin_run(1);
    feed();
    chk("post_rst_res", bus.res, 9);
    release_res();

    // Randomized runs, some long enough with large terms to overflow.
    for (int r = 0; r < 10; r++) begin
      int n;
      int big;
      n   = int'($urandom_range(40, 1));
      big = int'($urandom_range(1, 0));
      clear_terms();
      for (int i = 0; i < n; i++) begin
        if (big != 0) tp.push_back(int'($urandom_range(524287, 400000)));
        else          tp.push_back(int'($urandom_range(1048575, 0)) - 524288);
        ts.push_back((big != 0) ? 1'b0 : 1'($urandom));
        tg.push_back(int'($urandom_range(2, 0)));
      end
      begin_run(n);
      feed();
      release_res();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 10x10 signed multiplier stage.
- Accepts a stream of 20-bit signed products and accumulates a programmed number of terms into a wide signed accumulator, adding or subtracting per term.
- Presents the final sum to the next stage with a valid/ready handshake.
- Sits between the multiplier and the register-file writeback in the DSP/GPU arithmetic path.

Parameters:
- ACC_W, 40, accumulator and result width in bits (signed, minimum 21).
- CNT_W, 8, term-count width; a run holds up to 2^CNT_W-1 terms.

Ports:
- sys_clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a new run.
- len  in  CNT_W  number of terms in the run, sampled with start.
- prod  in  20  signed product from the multiplier stage.
- prod_sub  in  1  when high, the accepted term is subtracted instead of added.
- prod_valid  in  1  prod/prod_sub valid this cycle.
- prod_ready  out  1  block accepts a term this cycle.
- busy  out  1  high in ACCUM or HOLD.
- res  out  ACC_W  accumulated result.
- res_valid  out  1  res valid.
- res_ready  in  1  downstream accepts res.
- ovf  out  1  signed overflow occurred during the current or last run.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; acc, cnt, res=0; res_valid=0, prod_ready=0, busy=0, ovf=0. This applies mid-run; any partial sum is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and len!=0: acc<=0, cnt<=len, ovf<=0, go to ACCUM.
  - start=1 and len==0: acc<=0, ovf<=0, go to HOLD. Result 0 appears next cycle.
- ACCUM:
  - prod_ready=1 combinationally in this state only.
  - A term is accepted when prod_valid & prod_ready. The term is prod sign-extended to ACC_W, negated if prod_sub. acc<=acc±term; cnt<=cnt-1.
  - When cnt==1 and a term is accepted, go to HOLD. res<=updated sum; res_valid=1 on the next cycle (latency 1 cycle after the last accepted term).
  - prod_valid=0 leaves acc and cnt unchanged (stall).
  - start is ignored.
- HOLD:
  - res_valid=1; res stable.
  - res_ready=1: res_valid<=0 and go to IDLE.
  - If start=1 in the same cycle as res_ready, the new run is accepted directly (per IDLE rules). This back-to-back case must not lose a cycle.
  - start without res_ready is ignored.
- Arithmetic: two's complement, ACC_W bits.
  - Overflow: operands of equal sign (acc vs. effective term) and a result sign different from them. Sets ovf sticky until the next accepted start.
  - Default behaviour wraps modulo 2^ACC_W.
  - Negating prod=-2^19 is exact, since the term is extended before negation.
- busy = (state!=IDLE).
- ovf is valid alongside res_valid and holds after the handshake until the next start.

Optional Feature:
- Macro PROD_ACCUM_SAT_EN.
- Defined: on overflow, acc clamps to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative) instead of wrapping. Later terms continue from the clamped value. ovf is still set.
- Undefined: wrap-around only; no saturation logic is synthesised.

Decomposition:
- Package prod_accum_pkg contains:
  - state enum (IDLE, ACCUM, HOLD);
  - PROD_W=20 constant;
  - function sign-extending PROD_W to ACC_W.
- One sub-module, prod_accum_add: combinational ACC_W add/sub with overflow detect and the SAT_EN clamp. The top holds the FSM, counter and registers.

Test Plan:
- Basic run: start with len=3; products 100, -50, 7 (prod_sub=0), prod_valid every cycle. res=57 and res_valid one cycle after the third term; ovf=0.
- Subtract and stalls: len=2; term 1 is 1000 with prod_sub=1, then prod_valid=0 for 4 cycles, then term 2 is -262144 (-2^18) with prod_sub=1. res=261144; prod_ready stays high through the stall.
- len=0: start with len=0. res=0 and res_valid=1 next cycle; zero terms are accepted.
- Overflow (ACC_W=24): len=32, each term 262144.
  - Wrap build: res=-8388608 (0x800000), ovf=1.
  - PROD_ACCUM_SAT_EN build: res=8388607, ovf=1.
- Back-to-back runs:
  - Hold res_ready=0 for 3 cycles: res is stable and start pulses are ignored.
  - Assert res_ready and start(len=1) together: the state goes to ACCUM the next cycle and ovf clears.
- Reset mid-run: len=5, accept 2 terms, then assert reset for 1 cycle. All outputs read 0 and the state is IDLE. A new start with len=1 and term 9 gives res=9.
